jtgng_busarb: RTL and testbench
===============================

Name: jtgng_busarb

Overview:
- Responder side of the object-DMA bus handshake.
- Takes bus_req/blcnten/obj_AB from the object engine, halts the main 6809 CPU, and waits for the CPU to release the bus (BA=BS=1).
- Then grants bus_ack and steers main-RAM address and write enable to the object engine.
- Sits between the main CPU, main work RAM (8 kB) and the video block's object port.

Parameters:
- OBJ_BASE, 4'hF: main-RAM address bits [12:9] during DMA; the object table is at 0x1E00–0x1FFF.
- TIMEOUT, 8'd200: cen cycles allowed in HALT_WAIT before a forced grant.
- RELEASE_CYC, 2'd2: cen cycles ack stays low in RELEASE before the CPU is un-halted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- cen  in  1  CPU E-phase clock enable; all FSM transitions occur only on clk edges with cen=1
- bus_req  in  1  DMA request from the object engine
- bus_ack  out  1  DMA grant to the object engine
- blcnten  in  1  object engine bus-line counter enable; obj_AB is valid
- obj_AB  in  9  object engine RAM address
- cpu_AB  in  13  CPU address into main RAM
- cpu_ram_we  in  1  CPU RAM write strobe, already decoded
- cpu_ba  in  1  6809 BA
- cpu_bs  in  1  6809 BS
- cpu_halt_n  out  1  6809 HALT, active low
- ram_addr  out  13  main-RAM address
- ram_we  out  1  main-RAM write enable
- arb_err  out  1  sticky flag: the CPU failed to release the bus within TIMEOUT

Behaviour:
- Reset values (synchronous, asserted from any state):
  - state=IDLE, bus_ack=0, cpu_halt_n=1, arb_err=0, counters=0.
  - ram_addr=cpu_AB and ram_we=cpu_ram_we; these are combinational in IDLE.
- States: IDLE, HALT_WAIT, GRANT, RELEASE.
- IDLE:
  - cpu_halt_n=1.
  - On a cen edge with bus_req=1: go to HALT_WAIT, drive cpu_halt_n=0 (registered, visible the next clk), clear tcnt.
- HALT_WAIT:
  - cpu_halt_n=0. tcnt increments on each cen and saturates.
  - If bus_req drops: go to RELEASE. No ack is issued.
  - Else if cpu_ba&cpu_bs=1 on a cen edge: go to GRANT; bus_ack=1 registered on the same edge.
  - Else if tcnt reaches TIMEOUT-1: set arb_err=1, go to GRANT (forced grant).
- GRANT:
  - bus_ack=1, cpu_halt_n=0.
  - ram_we=0, so CPU writes are blocked.
  - ram_addr={OBJ_BASE,obj_AB} while blcnten=1; otherwise ram_addr={OBJ_BASE,9'd0}.
  - On the first cen edge with bus_req=0: bus_ack=0, go to RELEASE, clear rcnt.
- RELEASE:
  - bus_ack=0, cpu_halt_n stays 0, ram_addr=cpu_AB, ram_we=0.
  - rcnt increments on cen. At rcnt=RELEASE_CYC-1: cpu_halt_n=1, go to IDLE.
  - A new bus_req here is ignored until IDLE is reached, so there is a minimum RELEASE_CYC gap between grants.
- Latency:
  - bus_req to cpu_halt_n low: 1 cen edge.
  - BA&BS sampled high to bus_ack: that same cen edge (registered).
  - bus_req low to bus_ack low: 1 cen edge.
- Invariants:
  - bus_ack=1 implies cpu_halt_n=0.
  - bus_ack never rises in the same clk that bus_req is 0.
- Address mux switches only with the registered state; no glitching mux select.
- arb_err clears only on rst.

Decomposition:
- jtgng_busarb_pkg holds:
  - the state enum (IDLE=2'd0, HALT_WAIT=2'd1, GRANT=2'd2, RELEASE=2'd3);
  - OBJ_BASE default and the TIMEOUT width.
- One sub-module is natural: jtgng_busarb_mux, the purely combinational ram_addr/ram_we select driven by state, blcnten, obj_AB, cpu_AB and cpu_ram_we.
- The FSM and counters stay in the top.

Test Plan:
- Normal grant:
  - Stimulus: bus_req=1; cpu_ba=cpu_bs=1 after 3 cen.
  - Required: cpu_halt_n=0 after 1 cen; bus_ack=1 on the 4th cen; with obj_AB=9'h055 and blcnten=1, ram_addr=13'h1E55 and ram_we=0.
- Release:
  - Stimulus: drop bus_req in GRANT.
  - Required: bus_ack=0 after 1 cen; cpu_halt_n=1 after 2 further cen; ram_addr follows cpu_AB=13'h0123.
- Abort:
  - Stimulus: bus_req pulses for 2 cen while BA=BS=0.
  - Required: no bus_ack pulse; FSM returns to IDLE; arb_err=0.
- Timeout:
  - Stimulus: hold BA=BS=0 with TIMEOUT=200.
  - Required: at cen 200, arb_err=1 and bus_ack=1; arb_err remains 1 after the grant ends.
- Write blocking:
  - Stimulus: cpu_ram_we=1 throughout GRANT.
  - Required: ram_we=0 in GRANT and RELEASE; ram_we=1 in IDLE.
- Reset mid-GRANT:
  - Stimulus: rst=1 for 1 clk.
  - Required: on the next clk bus_ack=0, cpu_halt_n=1, arb_err=0, ram_addr=cpu_AB.

Source files
------------

// File: rtl/jtgng_busarb_pkg.sv
// Shared definitions for the object-DMA bus arbiter.
// Contents:
//   state_t           - arbiter FSM states
//   OBJ_BASE_DEF      - default main-RAM bits [12:9] during DMA (object table at 0x1E00-0x1FFF)
//   TCNT_W            - width of the halt-wait timeout counter
//   TIMEOUT_DEF       - default cen cycles allowed in HALT_WAIT before a forced grant
//   RELEASE_CYC_DEF   - default cen cycles spent in RELEASE before un-halting the CPU
//   tcnt_sat_inc()    - saturating increment for the timeout counter
package jtgng_busarb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HALT_WAIT = 2'd1,
        GRANT     = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    localparam logic [3:0] OBJ_BASE_DEF    = 4'hF;
    localparam int         TCNT_W          = 8;
    localparam logic [7:0] TIMEOUT_DEF     = 8'd200;
    localparam logic [1:0] RELEASE_CYC_DEF = 2'd2;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [TCNT_W-1:0] tcnt_sat_inc(input logic [TCNT_W-1:0] v);
        logic [TCNT_W-1:0] r;
        if (v == {TCNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(TCNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/jtgng_busarb_mux.sv
// Main-RAM address / write-enable steering for the object-DMA arbiter.
// Purely combinational; the select is the registered arbiter state, so the
// mux never switches on a combinational glitch.
// Ports:
//   state      in   registered arbiter state
//   blcnten    in   object engine address valid
//   obj_AB     in   object engine RAM address (9 bits)
//   cpu_AB     in   CPU RAM address (13 bits)
//   cpu_ram_we in   CPU RAM write strobe
//   ram_addr   out  main-RAM address (13 bits)
//   ram_we     out  main-RAM write enable
module jtgng_busarb_mux
    import jtgng_busarb_pkg::*;
#(
    parameter logic [3:0] OBJ_BASE = OBJ_BASE_DEF
)(
    input  state_t      state,
    input  logic        blcnten,
    input  logic [8:0]  obj_AB,
    input  logic [12:0] cpu_AB,
    input  logic        cpu_ram_we,
    output logic [12:0] ram_addr,
    output logic        ram_we
);

    // Select RAM address/write source from the arbiter state.
    always_comb begin
        ram_addr = cpu_AB;
        ram_we   = 1'b0;
        case (state)
            IDLE: begin
                ram_addr = cpu_AB;
                ram_we   = cpu_ram_we;
            end
            HALT_WAIT: begin
                // CPU keeps running until it acknowledges the halt.
                ram_addr = cpu_AB;
                ram_we   = cpu_ram_we;
            end
            GRANT: begin
                if (blcnten) begin
                    ram_addr = {OBJ_BASE, obj_AB};
                end else begin
                    ram_addr = {OBJ_BASE, 9'd0};
                end
                ram_we = 1'b0;
            end
            RELEASE: begin
                // CPU still halted; keep its writes blocked until IDLE.
                ram_addr = cpu_AB;
                ram_we   = 1'b0;
            end
            default: begin
                ram_addr = cpu_AB;
                ram_we   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/jtgng_busarb.sv
// Object-DMA bus arbiter (responder side). Halts the main 6809 on a DMA
// request, waits for BA=BS=1 (or a timeout), grants the bus to the object
// engine and steers main-RAM address/write enable accordingly.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   cen              CPU E-phase enable; FSM advances only when high
//   bus_req/bus_ack  DMA request in / grant out
//   blcnten, obj_AB  object engine address valid / address
//   cpu_AB, cpu_ram_we  CPU RAM address / decoded write strobe
//   cpu_ba, cpu_bs   6809 bus status
//   cpu_halt_n       6809 HALT (active low)
//   ram_addr, ram_we main-RAM address / write enable
//   arb_err          sticky: CPU did not release the bus within TIMEOUT
module jtgng_busarb
    import jtgng_busarb_pkg::*;
#(
    parameter logic [3:0]        OBJ_BASE    = OBJ_BASE_DEF,
    parameter logic [TCNT_W-1:0] TIMEOUT     = TIMEOUT_DEF,
    parameter logic [1:0]        RELEASE_CYC = RELEASE_CYC_DEF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        bus_req,
    output logic        bus_ack,
    input  logic        blcnten,
    input  logic [8:0]  obj_AB,
    input  logic [12:0] cpu_AB,
    input  logic        cpu_ram_we,
    input  logic        cpu_ba,
    input  logic        cpu_bs,
    output logic        cpu_halt_n,
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic        arb_err
);

    state_t              state_r, state_s;
    logic [TCNT_W-1:0]   tcnt_r, tcnt_s;
    logic [1:0]          rcnt_r, rcnt_s;
    logic                ack_r, ack_s;
    logic                halt_n_r, halt_n_s;
    logic                err_r, err_s;

    // Next-state and registered-output logic; everything holds when cen is low.
    always_comb begin
        state_s  = state_r;
        tcnt_s   = tcnt_r;
        rcnt_s   = rcnt_r;
        ack_s    = ack_r;
        halt_n_s = halt_n_r;
        err_s    = err_r;
        if (cen) begin
            case (state_r)
                IDLE: begin
                    ack_s = 1'b0;
                    if (bus_req) begin
                        state_s  = HALT_WAIT;
                        halt_n_s = 1'b0;
                        tcnt_s   = {TCNT_W{1'b0}};
                    end else begin
                        halt_n_s = 1'b1;
                    end
                end
                HALT_WAIT: begin
                    halt_n_s = 1'b0;
                    // Request is checked first so ack never rises with bus_req low.
                    if (!bus_req) begin
                        state_s = RELEASE;
                        rcnt_s  = 2'd0;
                        ack_s   = 1'b0;
                    end else if (cpu_ba && cpu_bs) begin
                        state_s = GRANT;
                        ack_s   = 1'b1;
                    end else if (tcnt_r == (TIMEOUT - 8'd1)) begin
                        // CPU never released the bus: force the grant and flag it.
                        state_s = GRANT;
                        ack_s   = 1'b1;
                        err_s   = 1'b1;
                    end else begin
                        tcnt_s = tcnt_sat_inc(tcnt_r);
                    end
                end
                GRANT: begin
                    halt_n_s = 1'b0;
                    if (!bus_req) begin
                        state_s = RELEASE;
                        ack_s   = 1'b0;
                        rcnt_s  = 2'd0;
                    end else begin
                        ack_s = 1'b1;
                    end
                end
                RELEASE: begin
                    ack_s = 1'b0;
                    // New requests wait until IDLE, guaranteeing a gap between grants.
                    if (rcnt_r == (RELEASE_CYC - 2'd1)) begin
                        state_s  = IDLE;
                        halt_n_s = 1'b1;
                    end else begin
                        rcnt_s   = rcnt_r + 2'd1;
                        halt_n_s = 1'b0;
                    end
                end
                default: begin
                    state_s  = IDLE;
                    ack_s    = 1'b0;
                    halt_n_s = 1'b1;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            tcnt_r   <= {TCNT_W{1'b0}};
            rcnt_r   <= 2'd0;
            ack_r    <= 1'b0;
            halt_n_r <= 1'b1;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            tcnt_r   <= tcnt_s;
            rcnt_r   <= rcnt_s;
            ack_r    <= ack_s;
            halt_n_r <= halt_n_s;
            err_r    <= err_s;
        end
    end

    assign bus_ack    = ack_r;
    assign cpu_halt_n = halt_n_r;
    assign arb_err    = err_r;

    jtgng_busarb_mux #(
        .OBJ_BASE   (OBJ_BASE)
    ) u_mux (
        .state      (state_r),
        .blcnten    (blcnten),
        .obj_AB     (obj_AB),
        .cpu_AB     (cpu_AB),
        .cpu_ram_we (cpu_ram_we),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we)
    );

endmodule

// File: tb/tb_jtgng_busarb.sv
// Directed self-checking bench for jtgng_busarb with hand-computed expectations.
module tb_jtgng_busarb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_ack;
    logic        blcnten = 1'b0;
    logic [8:0]  obj_AB = 9'd0;
    logic [12:0] cpu_AB = 13'd0;
    logic        cpu_ram_we = 1'b0;
    logic        cpu_ba = 1'b0;
    logic        cpu_bs = 1'b0;
    logic        cpu_halt_n;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic        arb_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic ack_seen;

    always #5 clk = ~clk;

    jtgng_busarb dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .bus_req    (bus_req),
        .bus_ack    (bus_ack),
        .blcnten    (blcnten),
        .obj_AB     (obj_AB),
        .cpu_AB     (cpu_AB),
        .cpu_ram_we (cpu_ram_we),
        .cpu_ba     (cpu_ba),
        .cpu_bs     (cpu_bs),
        .cpu_halt_n (cpu_halt_n),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .arb_err    (arb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk edge with cen high; returns at the following negedge.
    task automatic cen_cycle();
        @(negedge clk);
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
    endtask

    // One clk edge with cen low.
    task automatic idle_clk();
        @(negedge clk);
        cen = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_AB     = 13'h0123;
        cpu_ram_we = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack",    {31'd0, bus_ack},    32'd0);
        chk("rst_halt",   {31'd0, cpu_halt_n}, 32'd1);
        chk("rst_err",    {31'd0, arb_err},    32'd0);
        chk("rst_addr",   {19'd0, ram_addr},   32'h0123);
        chk("rst_we",     {31'd0, ram_we},     32'd1);

        // Normal grant: BA/BS come up after 3 cen.
        cpu_ram_we = 1'b0;
        obj_AB     = 9'h055;
        blcnten    = 1'b1;
        bus_req    = 1'b1;
        cen_cycle();
        chk("ng_halt1",   {31'd0, cpu_halt_n}, 32'd0);
        chk("ng_ack1",    {31'd0, bus_ack},    32'd0);
        chk("ng_hw_addr", {19'd0, ram_addr},   32'h0123);
        cen_cycle();
        cen_cycle();
        chk("ng_ack3",    {31'd0, bus_ack},    32'd0);
        cpu_ba = 1'b1;
        cpu_bs = 1'b1;
        cen_cycle();
        chk("ng_ack4",    {31'd0, bus_ack},    32'd1);
        chk("ng_halt4",   {31'd0, cpu_halt_n}, 32'd0);
        chk("ng_addr",    {19'd0, ram_addr},   32'h1E55);
        chk("ng_we",      {31'd0, ram_we},     32'd0);
        chk("ng_err",     {31'd0, arb_err},    32'd0);

        // Write blocking and idle address in GRANT; no cen, state holds.
        cpu_ram_we = 1'b1;
        blcnten    = 1'b0;
        idle_clk();
        chk("wb_we",      {31'd0, ram_we},     32'd0);
        chk("wb_addr0",   {19'd0, ram_addr},   32'h1E00);
        chk("wb_ackhold", {31'd0, bus_ack},    32'd1);

        // Release; a new request during RELEASE is ignored.
        bus_req = 1'b0;
        cpu_ba  = 1'b0;
        cpu_bs  = 1'b0;
        cen_cycle();
        chk("rl_ack",     {31'd0, bus_ack},    32'd0);
        chk("rl_halt0",   {31'd0, cpu_halt_n}, 32'd0);
        chk("rl_addr",    {19'd0, ram_addr},   32'h0123);
        chk("rl_we",      {31'd0, ram_we},     32'd0);
        bus_req = 1'b1;
        cen_cycle();
        chk("rl_halt1",   {31'd0, cpu_halt_n}, 32'd0);
        chk("rl_ack1",    {31'd0, bus_ack},    32'd0);
        bus_req = 1'b0;
        cen_cycle();
        chk("rl_halt2",   {31'd0, cpu_halt_n}, 32'd1);
        chk("rl_idle_we", {31'd0, ram_we},     32'd1);
        cen_cycle();
        chk("rl_gap",     {31'd0, cpu_halt_n}, 32'd1);

        // Abort: request for 2 cen while BA=BS=0.
        cpu_ram_we = 1'b0;
        ack_seen   = 1'b0;
        bus_req    = 1'b1;
        cen_cycle();
        ack_seen |= bus_ack;
        chk("ab_halt1",   {31'd0, cpu_halt_n}, 32'd0);
        cen_cycle();
        ack_seen |= bus_ack;
        bus_req = 1'b0;
        cen_cycle();
        ack_seen |= bus_ack;
        chk("ab_halt3",   {31'd0, cpu_halt_n}, 32'd0);
        cen_cycle();
        ack_seen |= bus_ack;
        chk("ab_halt4",   {31'd0, cpu_halt_n}, 32'd0);
        cen_cycle();
        ack_seen |= bus_ack;
        chk("ab_noack",   {31'd0, ack_seen},   32'd0);
        chk("ab_idle",    {31'd0, cpu_halt_n}, 32'd1);
        chk("ab_err",     {31'd0, arb_err},    32'd0);

        // Timeout: CPU never releases; forced grant on the 200th HALT_WAIT cen.
        bus_req  = 1'b1;
        cen_cycle();
        ack_seen = 1'b0;
        for (int i = 0; i < 199; i++) begin
            cen_cycle();
            ack_seen |= bus_ack;
        end
        chk("to_noack199", {31'd0, ack_seen},  32'd0);
        chk("to_noerr199", {31'd0, arb_err},   32'd0);
        blcnten = 1'b1;
        obj_AB  = 9'h1AA;
        cen_cycle();
        chk("to_ack200",  {31'd0, bus_ack},    32'd1);
        chk("to_err200",  {31'd0, arb_err},    32'd1);
        chk("to_halt",    {31'd0, cpu_halt_n}, 32'd0);
        chk("to_addr",    {19'd0, ram_addr},   32'h1FAA);
        bus_req = 1'b0;
        cen_cycle();
        chk("to_relack",  {31'd0, bus_ack},    32'd0);
        cen_cycle();
        cen_cycle();
        chk("to_idle",    {31'd0, cpu_halt_n}, 32'd1);
        chk("to_sticky",  {31'd0, arb_err},    32'd1);

        // Reset in the middle of a grant.
        bus_req = 1'b1;
        cpu_ba  = 1'b1;
        cpu_bs  = 1'b1;
        cen_cycle();
        cen_cycle();
        chk("mr_ack",     {31'd0, bus_ack},    32'd1);
        chk("mr_err",     {31'd0, arb_err},    32'd1);
        cpu_AB     = 13'h0ABC;
        cpu_ram_we = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_ack0",    {31'd0, bus_ack},    32'd0);
        chk("mr_halt1",   {31'd0, cpu_halt_n}, 32'd1);
        chk("mr_err0",    {31'd0, arb_err},    32'd0);
        chk("mr_addr",    {19'd0, ram_addr},   32'h0ABC);
        chk("mr_we",      {31'd0, ram_we},     32'd1);
        bus_req = 1'b0;
        idle_clk();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
